// File: rtl/pll_glitch_clock.sv
// pll_glitch_clock
// Qualifies PLL lock and divides the PLL clock down to the target clock.
// On an armed trigger it waits a programmable delay, then corrupts the
// target clock for a programmable number of PLL cycles in one of four modes.
// All logic runs on the rising edge of clock_in; reset is synchronous.
module pll_glitch_clock #(
    parameter int DIV_W       = 8,
    parameter int DLY_W       = 24,
    parameter int LEN_W       = 8,
    parameter int LOCK_CYCLES = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             locked,
    input  logic [DIV_W-1:0] half_period,
    input  logic [DLY_W-1:0] delay,
    input  logic [LEN_W-1:0] glitch_len,
    input  logic [1:0]       mode,
    input  logic             arm,
    input  logic             abort,
    input  logic             trigger,
    output logic             target_clock,
    output logic             glitch_active,
    output logic             ready,
    output logic             busy,
    output logic             done
);

    localparam int               LCK_W    = $clog2(LOCK_CYCLES + 1);
    localparam logic [LCK_W-1:0] LOCK_MAX = LCK_W'(LOCK_CYCLES);

    typedef enum logic [2:0] {
        WAIT_LOCK,
        IDLE,
        ARMED,
        DELAY,
        GLITCH,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        MODE_LOW,
        MODE_HIGH,
        MODE_INVERT,
        MODE_FREEZE
    } glitch_mode_t;

    // ------------------------------------------------------------------
    // Lock qualifier
    // ------------------------------------------------------------------
    logic [LCK_W-1:0] lock_cnt;
    logic [LCK_W-1:0] lock_cnt_next;

    // Count consecutive locked cycles, saturating; any unlocked cycle restarts.
    always_comb begin
        lock_cnt_next = lock_cnt;
        if (!locked) begin
            lock_cnt_next = '0;
        end else if (lock_cnt != LOCK_MAX) begin
            lock_cnt_next = lock_cnt + LCK_W'(1);
        end
    end

    // Lock counter and registered ready flag.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            lock_cnt <= '0;
            ready    <= 1'b0;
        end else begin
            lock_cnt <= lock_cnt_next;
            ready    <= locked && (lock_cnt_next == LOCK_MAX);
        end
    end

    // ------------------------------------------------------------------
    // Trigger synchroniser and rising-edge detector
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] trig_sync;
    logic                   trig_prev;
    logic                   trig_rise;

    // Bring the asynchronous trigger into the PLL domain and register its rising edge.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            trig_sync <= '0;
            trig_prev <= 1'b0;
            trig_rise <= 1'b0;
        end else begin
            trig_sync <= {trig_sync[SYNC_STAGES-2:0], trigger};
            trig_prev <= trig_sync[SYNC_STAGES-1];
            trig_rise <= trig_sync[SYNC_STAGES-1] & ~trig_prev;
        end
    end

    // ------------------------------------------------------------------
    // Target-clock divider
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_cnt_next;
    logic [DIV_W-1:0] hp_reg;
    logic [DIV_W-1:0] hp_next;
    logic [DIV_W-1:0] hp_eff;
    logic             div_clk;
    logic             div_clk_next;

    // A half period of zero behaves as one.
    assign hp_eff = (half_period == '0) ? DIV_W'(1) : half_period;

    // Divider next state: held cleared until qualified, half_period taken only at wrap.
    always_comb begin
        div_cnt_next = div_cnt;
        div_clk_next = div_clk;
        hp_next      = hp_reg;
        if (!locked || !ready) begin
            div_cnt_next = '0;
            div_clk_next = 1'b0;
            hp_next      = hp_eff;
        end else if (div_cnt == (hp_reg - DIV_W'(1))) begin
            div_cnt_next = '0;
            div_clk_next = ~div_clk;
            hp_next      = hp_eff;
        end else begin
            div_cnt_next = div_cnt + DIV_W'(1);
        end
    end

    // Divider registers; they keep running through a glitch so phase is kept.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            div_cnt <= '0;
            div_clk <= 1'b0;
            hp_reg  <= '0;
        end else begin
            div_cnt <= div_cnt_next;
            div_clk <= div_clk_next;
            hp_reg  <= hp_next;
        end
    end

    // ------------------------------------------------------------------
    // Glitch sequencing FSM
    // ------------------------------------------------------------------
    state_t           state;
    state_t           state_next;
    logic [DLY_W-1:0] dly_lat;
    logic [DLY_W-1:0] dly_lat_next;
    logic [DLY_W-1:0] dly_cnt;
    logic [DLY_W-1:0] dly_cnt_next;
    logic [LEN_W-1:0] len_cnt;
    logic [LEN_W-1:0] len_cnt_next;
    logic [LEN_W-1:0] len_eff;
    glitch_mode_t     mode_lat;
    glitch_mode_t     mode_lat_next;

    // A glitch length of zero behaves as one.
    assign len_eff = (glitch_len == '0) ? LEN_W'(1) : glitch_len;

    // Next-state logic; losing lock overrides everything and abort beats arm.
    always_comb begin
        state_next    = state;
        dly_lat_next  = dly_lat;
        dly_cnt_next  = dly_cnt;
        len_cnt_next  = len_cnt;
        mode_lat_next = mode_lat;
        if (!locked) begin
            state_next = WAIT_LOCK;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (ready) begin
                        state_next = IDLE;
                    end
                end
                IDLE: begin
                    if (abort) begin
                        state_next = IDLE;
                    end else if (arm) begin
                        state_next    = ARMED;
                        dly_lat_next  = delay;
                        len_cnt_next  = len_eff;
                        mode_lat_next = glitch_mode_t'(mode);
                    end
                end
                ARMED: begin
                    if (abort) begin
                        state_next = IDLE;
                    end else if (trig_rise) begin
                        state_next   = DELAY;
                        dly_cnt_next = dly_lat;
                    end
                end
                DELAY: begin
                    if (abort) begin
                        state_next = IDLE;
                    end else if (dly_cnt == '0) begin
                        state_next = GLITCH;
                    end else begin
                        dly_cnt_next = dly_cnt - DLY_W'(1);
                    end
                end
                GLITCH: begin
                    if (abort) begin
                        state_next = IDLE;
                    end else if (len_cnt <= LEN_W'(1)) begin
                        state_next = DONE;
                    end else begin
                        len_cnt_next = len_cnt - LEN_W'(1);
                    end
                end
                DONE: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = WAIT_LOCK;
                end
            endcase
        end
    end

    // FSM state and latched operation parameters.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state    <= WAIT_LOCK;
            dly_lat  <= '0;
            dly_cnt  <= '0;
            len_cnt  <= '0;
            mode_lat <= MODE_LOW;
        end else begin
            state    <= state_next;
            dly_lat  <= dly_lat_next;
            dly_cnt  <= dly_cnt_next;
            len_cnt  <= len_cnt_next;
            mode_lat <= mode_lat_next;
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic glitch_next;
    logic busy_next;
    logic done_next;
    logic target_next;

    // Outputs are decoded from the next state so they align with the state register.
    always_comb begin
        glitch_next = (state_next == GLITCH);
        busy_next   = (state_next == ARMED) || (state_next == DELAY) || (state_next == GLITCH);
        done_next   = (state_next == DONE);
        target_next = div_clk_next;
        if (!locked) begin
            target_next = 1'b0;
        end else if (glitch_next) begin
            case (mode_lat)
                MODE_LOW:    target_next = 1'b0;
                MODE_HIGH:   target_next = 1'b1;
                MODE_INVERT: target_next = ~div_clk_next;
                MODE_FREEZE: target_next = target_clock;
                default:     target_next = div_clk_next;
            endcase
        end
    end

    // Registered outputs so nothing combinational reaches the pins.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            target_clock  <= 1'b0;
            glitch_active <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            target_clock  <= target_next;
            glitch_active <= glitch_next;
            busy          <= busy_next;
            done          <= done_next;
        end
    end

endmodule
